uart_rx_mv: RTL and testbench

- Parametrised next-generation UART receiver for the same serial peripheral path as the current RX.
- Adds the following over the existing receiver:
  - runtime data length (5..DATA_WIDTH);
  - 1 or 2 stop bits;
  - 3-sample majority vote per bit;
  - input synchroniser;
  - valid/ready output handshake with a one-entry holding register and overrun detection.
- Sits between the RX_IN pad and the register/FIFO layer.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_sampler.sv | 60 ++++++
 rtl/uart_rx_mv.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_mv.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the multi-vote UART receiver.
// Optional break detection is enabled with the UART_RX_BREAK_DET_EN macro.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 6;

    // 2-of-3 vote used to reject single-sample noise on the line.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Data lengths outside 5..max_len fall back to the full width.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (int'(len) < 5 || int'(len) > max_len) begin
            return 4'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter.
// The counter runs 0..P-1 while run_i is high and sits at 0 otherwise.
// Samples are taken at P/2-1 and P/2; the third sample is the live line at
// P/2+1, where sample_strobe_o marks bit_val_o as the settled vote.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      run_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      rxs_i,
    output logic                      sample_strobe_o,
    output logic                      bit_val_o,
    output logic                      bit_done_o
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] half, last;
    logic                      s0_q, s0_d, s1_q, s1_d;

    assign half = prescale_i >> 1;
    assign last = prescale_i - 1'b1;

    // Advance the bit-time counter and capture the first two samples.
    always_comb begin
        edge_cnt_d = '0;
        s0_d       = s0_q;
        s1_d       = s1_q;
        if (run_i && edge_cnt_q != last) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (run_i && edge_cnt_q == half - 1'b1) begin
            s0_d = rxs_i;
        end
        if (run_i && edge_cnt_q == half) begin
            s1_d = rxs_i;
        end
    end

    // Counter and sample registers; samples rest at the idle line level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

    assign sample_strobe_o = run_i && (edge_cnt_q == half + 1'b1);
    assign bit_val_o       = majority3(s0_q, s1_q, rxs_i);
    assign bit_done_o      = run_i && (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx_mv.sv
// Oversampling UART receiver with majority vote, runtime frame format and a
// one-entry valid/ready holding register with overrun detection.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detection + BRK_WAIT).
//
// Output handshake: rx_valid is high while the holding register is full;
// a transfer happens in any cycle where rx_valid && rx_ready. P_DATA and the
// error flags stay stable while rx_valid is high. A frame completing while
// the register is full and not being drained is dropped and ovr_err pulses.
module uart_rx_mv
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [3:0]                data_len,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      stop_two,
    input  logic                      rx_ready,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      rx_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      ovr_err,
    output logic                      break_det,
    output rx_state_e                 dbg_state_o
);

    // Synchroniser and edge detect
    logic sync1_q, rxs_q, rxs_prev_q;

    // Frame FSM
    rx_state_e                 state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_acc_q, par_acc_d;
    logic                      par_bad_q, par_bad_d;
    logic                      stp_bad_q, stp_bad_d;
    logic                      zero_q, zero_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [3:0]                len_q, len_d;
    logic                      par_en_q, par_en_d;
    logic                      par_type_q, par_type_d;
    logic                      stop_two_q, stop_two_d;
    logic                      commit, commit_serr, brk_fire;

    // Holding register
    logic [DATA_WIDTH-1:0]     pdata_q, pdata_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;
    logic                      ovr_q, ovr_d;
    logic                      brk_q;

    // Sampler interface
    logic run, sample_strobe, bit_val, bit_done;

    assign run = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk_i           (CLK),
        .rst_ni          (RST),
        .run_i           (run),
        .prescale_i      (presc_q),
        .rxs_i           (rxs_q),
        .sample_strobe_o (sample_strobe),
        .bit_val_o       (bit_val),
        .bit_done_o      (bit_done)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= RX_IN;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Frame sequencing: votes are consumed at the sample strobe, state
    // advances at the end of each bit time.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        par_acc_d   = par_acc_q;
        par_bad_d   = par_bad_q;
        stp_bad_d   = stp_bad_q;
        zero_d      = zero_q;
        presc_d     = presc_q;
        len_d       = len_q;
        par_en_d    = par_en_q;
        par_type_d  = par_type_q;
        stop_two_d  = stop_two_q;
        commit      = 1'b0;
        commit_serr = stp_bad_q | ~bit_val;
        brk_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = START;
                    bit_cnt_d  = 4'd0;
                    data_d     = '0;
                    par_acc_d  = 1'b0;
                    par_bad_d  = 1'b0;
                    stp_bad_d  = 1'b0;
                    zero_d     = 1'b1;
                    presc_d    = Prescale;
                    len_d      = clamp_len(data_len, DATA_WIDTH);
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
                    stop_two_d = stop_two;
                end
            end
            START: begin
                if (sample_strobe) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end
                end else if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            DATA: begin
                if (sample_strobe) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == 4'(i)) begin
                            data_d[i] = bit_val;
                        end
                    end
                    par_acc_d = par_acc_q ^ bit_val;
                    zero_d    = zero_q & ~bit_val;
                end else if (bit_done) begin
                    if (bit_cnt_q == len_q - 4'd1) begin
                        bit_cnt_d = 4'd0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_strobe) begin
                    par_bad_d = bit_val != (par_acc_q ^ (par_type_q == PAR_ODD));
                    zero_d    = zero_q & ~bit_val;
                end else if (bit_done) begin
                    bit_cnt_d = 4'd0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample_strobe) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (bit_cnt_q == 4'd0 && zero_q && !bit_val) begin
                        brk_fire = 1'b1;
                        state_d  = BRK_WAIT;
                    end else
`endif
                    if (!stop_two_q || bit_cnt_q != 4'd0) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stp_bad_d = stp_bad_q | ~bit_val;
                    end
                end else if (bit_done) begin
                    bit_cnt_d = 4'd1;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BRK_WAIT: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM, frame accumulators and latched frame configuration.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
            zero_q     <= 1'b0;
            presc_q    <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop_two_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_acc_q  <= par_acc_d;
            par_bad_q  <= par_bad_d;
            stp_bad_q  <= stp_bad_d;
            zero_q     <= zero_d;
            presc_q    <= presc_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stop_two_q <= stop_two_d;
        end
    end

    // Holding register: load on commit when free or draining, else overrun.
    always_comb begin
        pdata_d = pdata_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        ovr_d   = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                pdata_d = data_q;
                perr_d  = par_bad_q;
                serr_d  = commit_serr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pdata_q <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_fire;
        end
    end

    assign P_DATA      = pdata_q;
    assign rx_valid    = valid_q;
    assign par_err     = perr_q;
    assign stp_err     = serr_q;
    assign ovr_err     = ovr_q;
    assign dbg_state_o = state_q;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det   = brk_q;
`else
    assign break_det   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_mv.sv
// Self-checking bench for uart_rx_mv: directed scenarios plus randomized
// frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_mv;
    import uart_rx_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd16;
    logic [3:0] data_len = 4'd8;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_two = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] P_DATA;
    logic       rx_valid, par_err, stp_err, ovr_err, break_det;
    rx_state_e  dbg_state;

    always #5 CLK = ~CLK;

    uart_rx_mv #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .Prescale      (Prescale),
        .data_len      (data_len),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .stop_two      (stop_two),
        .rx_ready      (rx_ready),
        .P_DATA        (P_DATA),
        .rx_valid      (rx_valid),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .ovr_err       (ovr_err),
        .break_det     (break_det),
        .dbg_state_o   (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    int rise_cnt = 0;
    logic valid_prev = 1'b0;
    logic [9:0] exp_q[$];

    // Event counters sampled away from the active edge.
    always @(negedge CLK) begin
        if (ovr_err) ovr_cnt++;
        if (break_det) brk_cnt++;
        if (rx_valid && !valid_prev) rise_cnt++;
        valid_prev = rx_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int eff_len(input int len_in);
        return (len_in < 5 || len_in > 8) ? 8 : len_in;
    endfunction

    function automatic logic [7:0] mask_word(input logic [7:0] d, input int n);
        logic [7:0] m;
        m = 8'((1 << n) - 1);
        return d & m;
    endfunction

    function automatic logic good_parity(input logic [7:0] word, input logic pt);
        return (^word) ^ pt;
    endfunction

    // Expected {stp_err, par_err, P_DATA} for one frame as sent on the line.
    function automatic logic [9:0] model_frame(input logic [7:0] d, input int len_in,
                                               input bit pe, input bit pt, input bit pbit,
                                               input bit s1, input bit st2, input bit s2);
        logic [7:0] word;
        bit perr, serr;
        word = mask_word(d, eff_len(len_in));
        perr = pe && (pbit != good_parity(word, pt));
        serr = !s1 || (st2 && !s2);
        return {serr, perr, word};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_cfg(input int p, input int len, input bit pe, input bit pt, input bit st2);
        Prescale = 6'(p);
        data_len = 4'(len);
        parity_enable = pe;
        parity_type = pt;
        stop_two = st2;
    endtask

    task automatic send_bit(input bit b, input int p, input bit glitch);
        for (int i = 0; i < p; i++) begin
            RX_IN = (glitch && i == p / 2) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    // Drives one frame; scramble changes the config inputs after start detection.
    task automatic send_frame(input logic [7:0] d, input int n, input int p, input bit pe,
                              input bit pbit, input bit s1, input bit st2, input bit s2,
                              input bit glitch, input bit scramble);
        RX_IN = 1'b0;
        cyc(4);
        if (scramble) begin
            Prescale = 6'($urandom_range(6, 62));
            data_len = 4'($urandom_range(0, 15));
            parity_enable = 1'($urandom_range(0, 1));
            parity_type = 1'($urandom_range(0, 1));
            stop_two = 1'($urandom_range(0, 1));
        end
        cyc(p - 4);
        for (int i = 0; i < n; i++) send_bit(d[i], p, glitch);
        if (pe) send_bit(pbit, p, 1'b0);
        send_bit(s1, p, 1'b0);
        if (st2) send_bit(s2, p, 1'b0);
        RX_IN = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rx_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b0;
        cyc(3);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got=%h want=00", P_DATA); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b want=00", {par_err, stp_err}); end
        checks++; if ({ovr_err, break_det} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {ovr_err, break_det}); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
        RST = 1'b1;
        cyc(4);
    endtask

    task automatic test_basic();
        bit seen;
        set_cfg(16, 8, 1, PAR_EVEN, 0);
        send_frame(8'hA5, 8, 16, 1, 1'b0, 1, 0, 1, 0, 0);
        wait_valid(64, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_valid got=timeout want=rx_valid"); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h want=a5", P_DATA); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL basic_errs got=%b want=00", {par_err, stp_err}); end
        consume();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_clear got=%b want=0", rx_valid); end
        cyc(8);
    endtask

    task automatic test_errors();
        // pflip, stop1, stop_two, stop2, expected par_err, expected stp_err
        bit tbl[3][6] = '{'{1, 1, 0, 1, 1, 0}, '{0, 0, 0, 1, 0, 1}, '{0, 1, 1, 0, 0, 1}};
        bit seen;
        for (int k = 0; k < 3; k++) begin
            set_cfg(16, 8, 1, PAR_EVEN, tbl[k][2]);
            send_frame(8'hA5, 8, 16, 1, tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], 0, 0);
            wait_valid(64, seen);
            checks++; if (!seen || P_DATA !== 8'hA5) begin errors++; $display("FAIL err%0d_data got=%h seen=%b want=a5", k, P_DATA, seen); end
            checks++; if (par_err !== tbl[k][4]) begin errors++; $display("FAIL err%0d_par got=%b want=%b", k, par_err, tbl[k][4]); end
            checks++; if (stp_err !== tbl[k][5]) begin errors++; $display("FAIL err%0d_stp got=%b want=%b", k, stp_err, tbl[k][5]); end
            consume();
            cyc(8);
        end
    endtask

    task automatic test_len5_glitch();
        bit seen;
        set_cfg(8, 5, 0, 0, 0);
        for (int g = 0; g < 2; g++) begin
            send_frame(8'h13, 5, 8, 0, 0, 1, 0, 1, g[0], 0);
            wait_valid(32, seen);
            checks++; if (!seen || P_DATA !== 8'h13) begin errors++; $display("FAIL len5_g%0d_data got=%h seen=%b want=13", g, P_DATA, seen); end
            checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL len5_g%0d_errs got=%b want=00", g, {par_err, stp_err}); end
            consume();
            cyc(6);
        end
    endtask

    task automatic test_start_glitch();
        int r0;
        set_cfg(16, 8, 1, 0, 0);
        r0 = rise_cnt;
        RX_IN = 1'b0;
        cyc(3);
        RX_IN = 1'b1;
        cyc(60);
        checks++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_novalid got=%0d want=0 frames", rise_cnt - r0); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL glitch_idle got=%0d want=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_back_to_back();
        int o0;
        set_cfg(16, 8, 1, 0, 0);
        o0 = ovr_cnt;
        send_frame(8'h55, 8, 16, 1, good_parity(8'h55, 0), 1, 0, 1, 0, 0);
        send_frame(8'hAA, 8, 16, 1, good_parity(8'hAA, 0), 1, 0, 1, 0, 0);
        cyc(32);
        checks++; if (rx_valid !== 1'b1 || P_DATA !== 8'h55) begin errors++; $display("FAIL ovr_hold got=%b/%h want=1/55", rx_valid, P_DATA); end
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse got=%0d want=1", ovr_cnt - o0); end
        consume();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want=0", rx_valid); end
        cyc(8);
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_cfg(16, 8, 0, 0, 0);
        send_frame(8'h77, 8, 16, 0, 0, 1, 0, 1, 0, 0);
        wait_valid(64, seen);
        checks++; if (!seen || P_DATA !== 8'h77) begin errors++; $display("FAIL rmid_pre got=%h seen=%b want=77", P_DATA, seen); end
        RX_IN = 1'b0;
        cyc(16);
        send_bit(1'b0, 16, 0);
        send_bit(1'b0, 16, 0);
        RST = 1'b0;
        cyc(1);
        checks++; if (rx_valid !== 1'b0 || P_DATA !== 8'h00) begin errors++; $display("FAIL rmid_out got=%b/%h want=0/00", rx_valid, P_DATA); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rmid_state got=%0d want=%0d", dbg_state, IDLE); end
        RST = 1'b1;
        RX_IN = 1'b1;
        cyc(20);
        send_frame(8'h3C, 8, 16, 0, 0, 1, 0, 1, 0, 0);
        wait_valid(64, seen);
        checks++; if (!seen || P_DATA !== 8'h3C || stp_err !== 1'b0) begin errors++; $display("FAIL rmid_next got=%h/%b seen=%b want=3c/0", P_DATA, stp_err, seen); end
        consume();
        cyc(8);
    endtask

    task automatic test_break();
        int b0, r0;
        set_cfg(16, 8, 1, 0, 0);
        b0 = brk_cnt;
        r0 = rise_cnt;
        RX_IN = 1'b0;
        cyc(12 * 16);
        RX_IN = 1'b1;
        cyc(48);
`ifdef UART_RX_BREAK_DET_EN
        checks++; if (brk_cnt - b0 != 1) begin errors++; $display("FAIL brk_pulse got=%0d want=1", brk_cnt - b0); end
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL brk_novalid got=%0d want=0", rise_cnt - r0); end
`else
        checks++; if (brk_cnt != b0) begin errors++; $display("FAIL brk_tied got=%0d want=0", brk_cnt - b0); end
        checks++; if (rx_valid !== 1'b1 || P_DATA !== 8'h00) begin errors++; $display("FAIL brk_data got=%b/%h want=1/00", rx_valid, P_DATA); end
        checks++; if ({stp_err, par_err} !== 2'b10) begin errors++; $display("FAIL brk_errs got=%b want=10", {stp_err, par_err}); end
        consume();
`endif
        cyc(8);
    endtask

    task automatic test_random();
        bit seen;
        int p, len_in, n;
        bit pe, pt, st2, pbit, s1, s2, gl;
        logic [7:0] d;
        logic [9:0] exp, got;
        for (int k = 0; k < 12; k++) begin
            p = 8 + 2 * $urandom_range(0, 4);
            len_in = $urandom_range(3, 12);
            n = eff_len(len_in);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            st2 = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (mask_word(d, n) == 8'h00) d[0] = 1'b1;
            pbit = good_parity(mask_word(d, n), pt) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            gl = 1'($urandom_range(0, 1));
            set_cfg(p, len_in, pe, pt, st2);
            exp_q.push_back(model_frame(d, len_in, pe, pt, pbit, s1, st2, s2));
            send_frame(d, n, p, pe, pbit, s1, st2, s2, gl, 1);
            wait_valid(4 * p, seen);
            exp = exp_q.pop_front();
            got = {stp_err, par_err, P_DATA};
            checks++; if (!seen) begin errors++; $display("FAIL rnd%0d_valid got=timeout want=rx_valid", k); end
            checks++; if (got !== exp) begin errors++; $display("FAIL rnd%0d_frame got=%h want=%h (len=%0d P=%0d)", k, got, exp, len_in, p); end
            cyc($urandom_range(0, 5));
            consume();
            cyc($urandom_range(2, 20));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_len5_glitch();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid();
        test_break();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
